byte_decode_stream: RTL and testbench

Streaming, parametrised successor to the combinational coefficient decoder. It consumes a frame of 32·ell bytes over a valid/ready byte stream and emits NUM_COEFFS ell-bit coefficients over a valid/ready coefficient stream. The coefficient width ell is selectable per frame, and an optional mod-Q reduction supports 12-bit public-key and ciphertext unpacking. It sits between the byte-oriented input path (seed/ciphertext buffers) and the polynomial/NTT datapath.

---
 rtl/kyber_codec_pkg.sv | 21 ++
 rtl/byte_decode_stream_bit_buffer.sv | 55 +++++
 rtl/byte_decode_stream.sv | 172 +++++++++++++++++
 tb/tb_byte_decode_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_codec_pkg.sv
// Shared constants, FSM state encoding and frame sizing for the coefficient codec blocks.
package kyber_codec_pkg;

   localparam int MAX_ELL    = 12;
   localparam int NUM_COEFFS = 256;
   localparam int Q          = 3329;
   localparam int ELL_W      = 4;
   localparam int BYTES_W    = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // A frame of 256 ell-bit coefficients occupies exactly 32*ell bytes.
   function automatic logic [BYTES_W-1:0] frame_bytes(input logic [ELL_W-1:0] ell);
      return {ell, 5'b0_0000};
   endfunction

endpackage

// File: rtl/byte_decode_stream_bit_buffer.sv
// LSB-first bit accumulator: bytes enter at the current fill level, coefficients leave from bit 0.
// Single-cycle update; push and pop may coincide, the byte then lands at cnt-ell.
module bit_buffer #(
   parameter int MAX_W = kyber_codec_pkg::MAX_ELL,
   parameter int BUF_W = MAX_W + 8,
   parameter int CNT_W = $clog2(BUF_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [7:0]       push_dat_i,
   input  logic             pop_i,
   input  logic [3:0]       ell_i,
   output logic [MAX_W-1:0] head_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [BUF_W-1:0] buf_q, buf_d, shifted;
   logic [CNT_W-1:0] cnt_q, cnt_d, base;

   always_comb begin
      shifted = buf_q;
      base    = cnt_q;
      if (pop_i) begin
         shifted = buf_q >> ell_i;
         base    = cnt_q - CNT_W'(ell_i);
      end
      buf_d = shifted;
      cnt_d = base;
      // Bits at and above the fill level are always zero, so OR-ing the byte in is safe.
      if (push_i) begin
         buf_d = shifted | (BUF_W'(push_dat_i) << base);
         cnt_d = base + CNT_W'(8);
      end
      if (clear_i) begin
         buf_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o = buf_q[MAX_W-1:0];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming byte-to-coefficient decoder with per-frame width ell and optional mod-Q reduction.
// Registered output stage; bytes are refused until the buffer holds fewer than ell bits.
module byte_decode_stream #(
   parameter int MAX_ELL    = kyber_codec_pkg::MAX_ELL,
   parameter int NUM_COEFFS = kyber_codec_pkg::NUM_COEFFS,
   parameter int Q          = kyber_codec_pkg::Q
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         ell,
   input  logic               reduce_en,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [MAX_ELL-1:0] out_coeff,
   output logic               out_last,
   input  logic               out_ready,
   output logic               busy,
   output logic               done,
   output logic               err
);
   import kyber_codec_pkg::*;

   localparam int BUF_W = MAX_ELL + 8;
   localparam int CNT_W = $clog2(BUF_W + 1);
   localparam int CF_W  = $clog2(NUM_COEFFS + 1);
   localparam logic [MAX_ELL:0]   ONE = (MAX_ELL + 1)'(1);
   localparam logic [MAX_ELL-1:0] QV  = MAX_ELL'(Q);

   state_t             state_q, state_d;
   logic [3:0]         ell_q, ell_d;
   logic               reduce_q, reduce_d;
   logic [8:0]         bytes_left_q, bytes_left_d;
   logic [CF_W-1:0]    coeffs_left_q, coeffs_left_d;
   logic               out_vld_q, out_vld_d;
   logic [MAX_ELL-1:0] coeff_q, coeff_d;
   logic               last_q, last_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [MAX_ELL-1:0] head, raw, reduced;
   logic [MAX_ELL:0]   mask_w;
   logic [CNT_W-1:0]   cnt;
   logic               legal, accept, extract, out_hs, clear;

   assign legal    = (ell != 4'd0) && (ell <= 4'(MAX_ELL));
   assign clear    = (state_q == IDLE) && start && legal;
   assign in_ready = (state_q == RUN) && (bytes_left_q != 9'd0) && (cnt < CNT_W'(ell_q));
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_vld_q && out_ready;
   assign extract  = (state_q != IDLE) && (coeffs_left_q != '0)
                     && (cnt >= CNT_W'(ell_q)) && (!out_vld_q || out_ready);

   // Raw value is below 2Q for every legal width, so one conditional subtract reduces fully.
   assign mask_w  = (ONE << ell_q) - ONE;
   assign raw     = head & mask_w[MAX_ELL-1:0];
   assign reduced = (reduce_q && (raw >= QV)) ? (raw - QV) : raw;

   bit_buffer #(
      .MAX_W (MAX_ELL),
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_bit_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear),
      .push_i     (accept),
      .push_dat_i (in_data),
      .pop_i      (extract),
      .ell_i      (ell_q),
      .head_o     (head),
      .cnt_o      (cnt)
   );

   always_comb begin
      state_d       = state_q;
      ell_d         = ell_q;
      reduce_d      = reduce_q;
      bytes_left_d  = bytes_left_q;
      coeffs_left_d = coeffs_left_q;
      out_vld_d     = out_vld_q;
      coeff_d       = coeff_q;
      last_d        = last_q;
      done_d        = 1'b0;
      err_d         = 1'b0;

      if (extract) begin
         out_vld_d     = 1'b1;
         coeff_d       = reduced;
         last_d        = (coeffs_left_q == CF_W'(1));
         coeffs_left_d = coeffs_left_q - CF_W'(1);
      end else if (out_hs) begin
         out_vld_d = 1'b0;
         last_d    = 1'b0;
      end

      if (accept) begin
         bytes_left_d = bytes_left_q - 9'd1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (legal) begin
                  state_d       = RUN;
                  ell_d         = ell;
                  reduce_d      = reduce_en;
                  bytes_left_d  = frame_bytes(ell);
                  coeffs_left_d = CF_W'(NUM_COEFFS);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept && (bytes_left_q == 9'd1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_hs && last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ell_q         <= '0;
         reduce_q      <= 1'b0;
         bytes_left_q  <= '0;
         coeffs_left_q <= '0;
         out_vld_q     <= 1'b0;
         coeff_q       <= '0;
         last_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         ell_q         <= ell_d;
         reduce_q      <= reduce_d;
         bytes_left_q  <= bytes_left_d;
         coeffs_left_q <= coeffs_left_d;
         out_vld_q     <= out_vld_d;
         coeff_q       <= coeff_d;
         last_q        <= last_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   // Every frame consumes its bytes exactly, so leftover bits at done mean a counting bug.
   always @(posedge clk) begin
      if (rst_n && done_q) begin
         assert (cnt == '0);
      end
   end

   assign out_valid = out_vld_q;
   assign out_coeff = coeff_q;
   assign out_last  = last_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Directed bench for byte_decode_stream: fixed patterns, reduction, stalls, illegal widths, reset.
module tb_byte_decode_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ell = 4'd0;
   logic        reduce_en = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        out_valid;
   logic [11:0] out_coeff;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  fbytes [0:383];
   logic [11:0] got [$];
   int          last_pos;
   int          stall_viol;

   always #5 clk = ~clk;

   byte_decode_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ell       (ell),
      .reduce_en (reduce_en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_coeff (out_coeff),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Reference: coefficient i, bit j is stream bit i*e+j; stream bit 8k+b is byte k bit b.
   function automatic logic [11:0] model_coeff(input int i, input int e, input bit red);
      logic [11:0] r;
      int p;
      r = '0;
      for (int j = 0; j < e; j++) begin
         p = i * e + j;
         r[j] = fbytes[p / 8][p % 8];
      end
      if (red && r >= 12'd3329) r = r - 12'd3329;
      return r;
   endfunction

   // Entered and left on a falling edge; returns in the cycle done is high.
   task automatic run_frame(input int e, input bit red, input bit stall, input bit gaps);
      int  nb;
      int  src_idx;
      bit  src_to, snk_to;
      logic done_obs, busy_obs;
      nb = 32 * e;
      src_idx = 0;
      src_to = 1'b0;
      snk_to = 1'b0;
      got.delete();
      last_pos = -1;
      stall_viol = 0;
      start = 1'b1;
      ell = e[3:0];
      reduce_en = red;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL frame_start ell=%0d busy=%b want 1", e, busy);
      else n_pass++;
      fork
         begin : src
            int cyc;
            cyc = 0;
            while (src_idx < nb && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               if (gaps && $urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
               end else begin
                  in_valid = 1'b1;
                  in_data = fbytes[src_idx];
               end
               if (in_valid && in_ready) src_idx++;
            end
            if (src_idx < nb) src_to = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin : snk
            int   cyc;
            bit   fin, hold;
            logic [11:0] held;
            cyc = 0;
            fin = 1'b0;
            hold = 1'b0;
            held = '0;
            while (!fin && cyc < 20000) begin
               @(negedge clk);
               cyc++;
               if (hold && (out_valid !== 1'b1 || out_coeff !== held)) stall_viol++;
               hold = 1'b0;
               out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
               if (out_valid && out_ready) begin
                  got.push_back(out_coeff);
                  if (out_last) begin
                     last_pos = got.size() - 1;
                     fin = 1'b1;
                  end
               end else if (out_valid) begin
                  hold = 1'b1;
                  held = out_coeff;
               end
            end
            if (!fin) snk_to = 1'b1;
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      done_obs = done;
      busy_obs = busy;
      n_checks++;
      if ({src_to, snk_to} !== 2'b00) $display("FAIL frame_timeout ell=%0d src_to=%b snk_to=%b want 0/0", e, src_to, snk_to);
      else n_pass++;
      n_checks++;
      if (got.size() !== 256) $display("FAIL coeff_count ell=%0d got %0d want 256", e, got.size());
      else n_pass++;
      n_checks++;
      if (last_pos !== 255) $display("FAIL last_index ell=%0d got %0d want 255", e, last_pos);
      else n_pass++;
      n_checks++;
      if (stall_viol !== 0) $display("FAIL stall_stable ell=%0d violations=%0d want 0", e, stall_viol);
      else n_pass++;
      n_checks++;
      if ({done_obs, busy_obs} !== 2'b10) $display("FAIL done_timing ell=%0d done=%b busy=%b want 1/0", e, done_obs, busy_obs);
      else n_pass++;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_last, busy, done, err, out_coeff} !== 18'd0)
         $display("FAIL reset_hold outputs=%b want all 0", {in_ready, out_valid, out_last, busy, done, err, out_coeff});
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, out_last, busy, done, err, out_coeff} !== 18'd0)
         $display("FAIL reset_release outputs=%b want all 0", {in_ready, out_valid, out_last, busy, done, err, out_coeff});
      else n_pass++;
   endtask

   task automatic test_err_ell;
      int bad;
      for (int k = 0; k < 2; k++) begin
         bad = (k == 0) ? 0 : 13;
         start = 1'b1;
         ell = bad[3:0];
         @(negedge clk);
         start = 1'b0;
         n_checks++;
         if ({err, busy, in_ready} !== 3'b100) $display("FAIL err_pulse ell=%0d err/busy/in_ready=%b want 100", bad, {err, busy, in_ready});
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if ({err, busy, in_ready} !== 3'b000) $display("FAIL err_clear ell=%0d err/busy/in_ready=%b want 000", bad, {err, busy, in_ready});
         else n_pass++;
      end
   endtask

   task automatic test_ell1_pattern;
      logic [7:0] pat;
      logic [11:0] exp;
      int bad, first;
      pat = 8'hA5;
      for (int i = 0; i < 32; i++) fbytes[i] = 8'hA5;
      run_frame(1, 1'b0, 1'b0, 1'b0);
      bad = 0;
      first = -1;
      for (int i = 0; i < got.size(); i++) begin
         exp = {11'd0, pat[i % 8]};
         if (got[i] !== exp) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_checks++;
      if (bad !== 0) $display("FAIL ell1_values mismatches=%0d first_index=%0d want 0 mismatches", bad, first);
      else n_pass++;
   endtask

   task automatic test_ell4;
      logic [47:0] head4;
      int bad;
      fbytes[0] = 8'h3C;
      fbytes[1] = 8'h21;
      for (int i = 2; i < 128; i++) fbytes[i] = 8'(i * 7 + 3);
      run_frame(4, 1'b0, 1'b0, 1'b0);
      head4 = (got.size() >= 4) ? {got[0], got[1], got[2], got[3]} : 48'hFFFF_FFFF_FFFF;
      n_checks++;
      if (head4 !== {12'hC, 12'h3, 12'h1, 12'h2}) $display("FAIL ell4_first4 got %h want 00c003001002", head4);
      else n_pass++;
      bad = 0;
      for (int i = 4; i < got.size(); i++) if (got[i] !== model_coeff(i, 4, 1'b0)) bad++;
      n_checks++;
      if (bad !== 0) $display("FAIL ell4_rest mismatches=%0d want 0", bad);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [11:0] exp;
      int bad;
      for (int i = 0; i < 384; i++) fbytes[i] = 8'hFF;
      for (int k = 0; k < 2; k++) begin
         exp = (k == 0) ? 12'd766 : 12'd4095;
         run_frame(12, (k == 0), 1'b0, 1'b0);
         bad = 0;
         for (int i = 0; i < got.size(); i++) if (got[i] !== exp) bad++;
         n_checks++;
         if (bad !== 0) $display("FAIL ell12_ff reduce=%0d mismatches=%0d want all %0d", (k == 0), bad, exp);
         else n_pass++;
      end
   endtask

   task automatic test_ell10_stall;
      int bad;
      for (int i = 0; i < 320; i++) fbytes[i] = 8'($urandom_range(0, 255));
      run_frame(10, 1'b1, 1'b1, 1'b1);
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== model_coeff(i, 10, 1'b0)) bad++;
      n_checks++;
      if (bad !== 0) $display("FAIL ell10_stream mismatches=%0d want 0", bad);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame;
      int acc, cyc, bad;
      start = 1'b1;
      ell = 4'd11;
      reduce_en = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 100 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b1;
         in_data = 8'(cyc * 13);
         if (in_ready) acc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, out_last, busy, done, err, out_coeff} !== 18'd0 || acc !== 100)
         $display("FAIL midframe_reset outputs=%b bytes=%0d want all 0 after 100 bytes", {in_ready, out_valid, out_last, busy, done, err, out_coeff}, acc);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, done, in_ready, out_valid} !== 4'b0000) $display("FAIL after_reset busy/done/in_ready/out_valid=%b want 0000", {busy, done, in_ready, out_valid});
      else n_pass++;
      for (int i = 0; i < 160; i++) fbytes[i] = 8'($urandom_range(0, 255));
      run_frame(5, 1'b1, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== model_coeff(i, 5, 1'b0)) bad++;
      n_checks++;
      if (bad !== 0) $display("FAIL ell5_after_reset mismatches=%0d want 0", bad);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation exceeded time limit, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_err_ell();
      test_ell1_pattern();
      test_ell4();
      test_back_to_back();
      test_ell10_stall();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
